// File: rtl/gauss_sample_stream.sv
// Output stage behind the Box-Muller generator: buffers cos/sin pairs in a small FIFO,
// applies saturating affine scaling and serialises them cos-first onto a valid/ready stream.
module gauss_sample_stream #(
  parameter int                     W     = 32,
  parameter int                     DEPTH = 8,
  parameter int                     AW    = 3,
  parameter int                     OW    = 16,
  parameter logic [15:0]            SIGMA = 16'h0100,
  parameter int                     SHIFT = 8,
  parameter logic signed [OW-1:0]   MEAN  = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  in_cos,
  input  logic [W-1:0]  in_sin,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_sel,
  output logic [AW:0]   level,
  output logic          overflow
);

  localparam logic [AW:0]         FULL   = (AW+1)'(DEPTH);
  localparam logic signed [W+17:0] SAT_HI = {{(W+19-OW){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [W+17:0] SAT_LO = {{(W+19-OW){1'b1}}, {(OW-1){1'b0}}};

  // Pair storage: cos in the upper half, sin in the lower half.
  logic [2*W-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          phase_q, phase_d;
  logic          out_valid_q, out_valid_d;
  logic [OW-1:0] out_data_q, out_data_d;
  logic          out_sel_q, out_sel_d;
  logic          overflow_q, overflow_d;

  logic          wr_en;
  logic          load;
  logic          pop;
  logic [2*W-1:0] head;
  logic [W-1:0]  head_sample;

  // Floor-shifted product plus offset, clamped to the signed OW-bit range.
  function automatic logic [OW-1:0] scale(input logic [W-1:0] x);
    logic signed [W+16:0] p;
    logic signed [W+16:0] s;
    logic signed [W+17:0] t;
    p = (W+17)'($signed(x)) * (W+17)'($signed({1'b0, SIGMA}));
    s = p >>> SHIFT;
    t = (W+18)'(s) + (W+18)'(MEAN);
    if (t > SAT_HI)      t = SAT_HI;
    else if (t < SAT_LO) t = SAT_LO;
    return t[OW-1:0];
  endfunction

  assign in_ready    = (level_q != FULL);
  assign wr_en       = in_valid && in_ready;
  assign load        = (!out_valid_q || out_ready) && (level_q != '0);
  assign pop         = load && phase_q;
  assign head        = mem_q[rd_ptr_q];
  assign head_sample = phase_q ? head[W-1:0] : head[2*W-1:W];

  // NOTE: every variable assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    phase_d     = phase_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    overflow_d  = overflow_q | (in_valid && !in_ready);

    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);

    case ({wr_en, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = scale(head_sample);
      out_sel_d   = phase_q;
      phase_d     = ~phase_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      phase_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      phase_q     <= phase_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; resetting the pointers makes old entries unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {in_cos, in_sin};
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_gauss_sample_stream.sv
// Self-checking bench: per-cycle comparison against a queue-based sample model, plus
// table-driven scaling vectors and hand-written backpressure/overflow/reset sequences.
module tb_gauss_sample_stream;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        in_valid, out_ready;
  logic [31:0] in_cos, in_sin;
  logic        in_ready, out_valid, out_sel, overflow;
  logic [15:0] out_data;
  logic [3:0]  level;

  // Second instance with a half-scale SIGMA to exercise floor rounding.
  logic        v2;
  logic [31:0] c2, s2;
  logic        in_ready2, out_valid2, out_sel2, overflow2;
  logic [15:0] out_data2;
  logic [3:0]  level2;

  gauss_sample_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_cos(in_cos), .in_sin(in_sin),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .level(level), .overflow(overflow)
  );

  gauss_sample_stream #(.SIGMA(16'h0080)) dut_half (
    .clk(clk), .rst(rst), .in_valid(v2), .in_cos(c2), .in_sin(s2),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(1'b1),
    .out_data(out_data2), .out_sel(out_sel2), .level(level2), .overflow(overflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int xfers = 0;

  typedef struct { logic [15:0] data; logic sel; } smp_t;
  smp_t        sq[$];
  logic        m_valid, m_sel, m_ovf;
  logic [15:0] m_data;

  typedef struct {
    logic [31:0] cos_in;
    logic [31:0] sin_in;
    logic [15:0] exp_cos;
    logic [15:0] exp_sin;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain-arithmetic reference: multiply, floor-divide by 2^shift, clamp to int16.
  function automatic logic [15:0] scale_ref(input logic [31:0] x, input longint sigma);
    longint p, s, d;
    d = 64'sd1 << 8;
    p = longint'($signed(x)) * sigma;
    s = p / d;
    if (p < 0 && (p % d) != 0) s = s - 1;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  function automatic int model_level();
    return (sq.size() + 1) / 2;
  endfunction

  task automatic model_edge();
    bit accept;
    if (!rst) begin
      sq.delete();
      m_valid = 1'b0; m_data = '0; m_sel = 1'b0; m_ovf = 1'b0;
    end else begin
      accept = in_valid && (model_level() != DEPTH);
      if (in_valid && !accept) m_ovf = 1'b1;
      if (m_valid && out_ready) xfers++;
      if ((!m_valid || out_ready) && sq.size() != 0) begin
        smp_t s;
        s = sq.pop_front();
        m_data = s.data; m_sel = s.sel; m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (accept) begin
        sq.push_back('{data: scale_ref(in_cos, 256), sel: 1'b0});
        sq.push_back('{data: scale_ref(in_sin, 256), sel: 1'b1});
      end
    end
  endtask

  task automatic step(input logic v, input logic [31:0] c, input logic [31:0] s,
                      input logic rdy, input logic r);
    logic [23:0] exp_vec;
    in_valid = v; in_cos = c; in_sin = s; out_ready = rdy; rst = r;
    @(posedge clk);
    model_edge();
    #1;
    exp_vec = {model_level() != DEPTH, m_valid, m_data, m_sel, 4'(model_level()), m_ovf};
    check("cycle", {in_ready, out_valid, out_data, out_sel, level, overflow}, exp_vec);
  endtask

  vec_t vecs[6];
  vec_t half_vecs[3];

  initial begin
    vecs[0] = '{32'd100,        -32'sd5,       16'd100,    -16'sd5};
    vecs[1] = '{32'd40000,      -32'sd40000,   16'h7fff,   16'h8000};
    vecs[2] = '{32'd32767,      -32'sd32768,   16'h7fff,   16'h8000};
    vecs[3] = '{32'd0,          -32'sd1,       16'd0,      16'hffff};
    vecs[4] = '{-32'sd70000,    32'd70000,     16'h8000,   16'h7fff};
    vecs[5] = '{32'h7fffffff,   32'h80000000,  16'h7fff,   16'h8000};
    half_vecs[0] = '{-32'sd1,   -32'sd3,       16'hffff,   -16'sd2};
    half_vecs[1] = '{32'd3,     32'd5,         16'd1,      16'd2};
    half_vecs[2] = '{-32'sd256, 32'd255,       -16'sd128,  16'd127};

    v2 = 1'b0; c2 = '0; s2 = '0;
    m_valid = 1'b0; m_data = '0; m_sel = 1'b0; m_ovf = 1'b0;

    // Reset state
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("reset_state", {out_valid, out_data, out_sel, level, overflow, in_ready}, {1'b0, 16'd0, 1'b0, 4'd0, 1'b0, 1'b1});

    // Scaling vectors at default parameters, consumer always ready
    for (int i = 0; i < 6; i++) begin
      step(1, vecs[i].cos_in, vecs[i].sin_in, 1, 1);
      check("vec_level_after_write", level, 4'd1);
      step(0, 0, 0, 1, 1);
      check("vec_cos", {out_valid, out_sel, out_data}, {1'b1, 1'b0, vecs[i].exp_cos});
      step(0, 0, 0, 1, 1);
      check("vec_sin", {out_valid, out_sel, out_data, level}, {1'b1, 1'b1, vecs[i].exp_sin, 4'd0});
      step(0, 0, 0, 1, 1);
    end

    // Floor rounding on the half-scale instance
    for (int i = 0; i < 3; i++) begin
      v2 = 1'b1; c2 = half_vecs[i].cos_in; s2 = half_vecs[i].sin_in;
      step(0, 0, 0, 1, 1);
      v2 = 1'b0;
      step(0, 0, 0, 1, 1);
      check("half_cos", {out_valid2, out_sel2, out_data2}, {1'b1, 1'b0, half_vecs[i].exp_cos});
      step(0, 0, 0, 1, 1);
      check("half_sin", {out_valid2, out_sel2, out_data2}, {1'b1, 1'b1, half_vecs[i].exp_sin});
      step(0, 0, 0, 1, 1);
    end

    // Backpressure: head sample holds, then transfers with no bubble
    step(1, 32'd1234, -32'sd777, 0, 1);
    step(1, 32'd55, 32'd66, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1);
      check("hold", {out_valid, out_sel, out_data}, {1'b1, 1'b0, 16'd1234});
    end
    step(0, 0, 0, 1, 1);
    check("release_sin", {out_valid, out_sel, out_data}, {1'b1, 1'b1, -16'sd777});
    step(0, 0, 0, 1, 1);
    check("next_cos", {out_valid, out_sel, out_data}, {1'b1, 1'b0, 16'd55});
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    check("bp_drained", {out_valid, level}, {1'b0, 4'd0});

    // Overflow: ten back-to-back pairs into a stalled stream
    for (int i = 0; i < 10; i++) step(1, 32'(i * 1000 + 1), 32'(-(i * 1000 + 7)), 0, 1);
    check("ovf_full", {level, in_ready, overflow}, {4'd8, 1'b0, 1'b1});
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 1);
    check("ovf_sticky", {level, out_valid, overflow}, {4'd0, 1'b0, 1'b1});

    // Reset mid-operation (write attempted on the reset edge too)
    for (int i = 0; i < 5; i++) step(1, 32'(i + 10), 32'(i + 20), 0, 1);
    check("pre_reset", {level, out_valid}, {4'd5, 1'b1});
    step(1, 32'd7, 32'd8, 0, 0);
    check("mid_reset", {out_valid, level, overflow, out_data, out_sel}, {1'b0, 4'd0, 1'b0, 16'd0, 1'b0});
    step(1, 32'd321, -32'sd9, 1, 1);
    step(0, 0, 0, 1, 1);
    check("post_reset_cos", {out_valid, out_sel, out_data}, {1'b1, 1'b0, 16'd321});
    step(0, 0, 0, 1, 1);
    check("post_reset_sin", {out_valid, out_sel, out_data}, {1'b1, 1'b1, -16'sd9});
    step(0, 0, 0, 1, 1);

    // Randomised stream: 20 pairs, one per two cycles at most, random stalls, no drops
    begin
      int sent = 0;
      int cyc = 0;
      int xfers_start;
      logic [31:0] rc, rs;
      xfers_start = xfers;
      while (sent < 20 && cyc < 2000) begin
        logic rdy;
        rdy = ($urandom_range(0, 3) != 0);
        if (cyc[0] == 1'b0 && model_level() != DEPTH) begin
          rc = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 80000)) - 32'd40000;
          rs = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 80000)) - 32'd40000;
          step(1, rc, rs, rdy, 1);
          sent++;
        end else begin
          step(0, 0, 0, rdy, 1);
        end
        cyc++;
      end
      for (int i = 0; i < 60; i++) step(0, 0, 0, 1, 1);
      check("rand_transfers", 64'(xfers - xfers_start), 64'd40);
      check("rand_no_drop", {overflow, level, out_valid}, {1'b0, 4'd0, 1'b0});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
